// File: rtl/fp_cmp_pkg.sv
// Shared constants and mode decode for the FloPoCo floating-point comparator.
// Exception codes follow the FloPoCo {exn, sign, exp, frac} operand layout.
package fp_cmp_pkg;

   localparam logic [1:0] EXN_ZERO = 2'b00;
   localparam logic [1:0] EXN_NORM = 2'b01;
   localparam logic [1:0] EXN_INF  = 2'b10;
   localparam logic [1:0] EXN_NAN  = 2'b11;

   localparam logic [2:0] CMP_LT = 3'd0;
   localparam logic [2:0] CMP_LE = 3'd1;
   localparam logic [2:0] CMP_EQ = 3'd2;
   localparam logic [2:0] CMP_NE = 3'd3;
   localparam logic [2:0] CMP_GE = 3'd4;
   localparam logic [2:0] CMP_GT = 3'd5;

   // Unordered pairs arrive with all flags low, so only NE (= !eq) reports 1.
   function automatic logic decode_mode(input logic [2:0] mode, input logic lt,
                                        input logic eq, input logic gt);
      logic res;
      case (mode)
         CMP_LT:  res = lt;
         CMP_LE:  res = lt | eq;
         CMP_EQ:  res = eq;
         CMP_NE:  res = !eq;
         CMP_GE:  res = gt | eq;
         CMP_GT:  res = gt;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/fp_cmp_classify.sv
// Combinational ordering of two FloPoCo operands using magnitude keys only;
// produces raw lt/eq/gt flags plus the unordered (NaN) indication.
module fp_cmp_classify #(
   parameter int unsigned WE = 11,
   parameter int unsigned WF = 20,
   localparam int unsigned W  = WE + WF + 3,
   localparam int unsigned KW = WE + WF + 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         lt,
   output logic         eq,
   output logic         gt,
   output logic         unordered
);
   import fp_cmp_pkg::*;

   logic [1:0]    exn_a, exn_b;
   logic          sign_a, sign_b;
   logic [KW-1:0] key_a, key_b;

   always_comb begin
      exn_a  = a[W-1 -: 2];
      exn_b  = b[W-1 -: 2];
      sign_a = a[W-3];
      sign_b = b[W-3];
      // Zero and infinity carry don't-care exp/frac bits; mask so keys order cleanly.
      key_a  = {exn_a, a[W-4:0]};
      key_b  = {exn_b, b[W-4:0]};
      if (exn_a == EXN_ZERO || exn_a == EXN_INF) key_a[KW-3:0] = '0;
      if (exn_b == EXN_ZERO || exn_b == EXN_INF) key_b[KW-3:0] = '0;

      lt        = 1'b0;
      eq        = 1'b0;
      gt        = 1'b0;
      unordered = 1'b0;
      if (exn_a == EXN_NAN || exn_b == EXN_NAN) begin
         unordered = 1'b1;
      end else if (exn_a == EXN_ZERO && exn_b == EXN_ZERO) begin
         eq = 1'b1;
      end else if (sign_a != sign_b) begin
         lt = sign_a;
         gt = sign_b;
      end else begin
         eq = (key_a == key_b);
         lt = sign_a ? (key_a > key_b) : (key_a < key_b);
         gt = !lt && !eq;
      end
   end

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined six-mode floating-point comparator with valid/ready flow control.
// One global enable stalls every stage together; bubbles are not squeezed.
module fp_compare_pipe #(
   parameter int unsigned WE     = 11,
   parameter int unsigned WF     = 20,
   parameter int unsigned STAGES = 2,
   localparam int unsigned W     = WE + WF + 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [2:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         result,
   output logic         unordered,
   output logic         lt,
   output logic         eq,
   output logic         gt
);
   import fp_cmp_pkg::*;

   logic       en;
   logic       c_lt, c_eq, c_gt, c_unord;
   logic       p_valid, p_lt, p_eq, p_gt, p_unord;
   logic [2:0] p_mode;

   logic out_valid_q, out_valid_d;
   logic result_q, result_d;
   logic unord_q, unord_d;
   logic lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   fp_cmp_classify #(
      .WE(WE),
      .WF(WF)
   ) u_classify (
      .a        (in_a),
      .b        (in_b),
      .lt       (c_lt),
      .eq       (c_eq),
      .gt       (c_gt),
      .unordered(c_unord)
   );

   if (STAGES == 1) begin : g_single
      assign p_valid = in_valid;
      assign p_lt    = c_lt;
      assign p_eq    = c_eq;
      assign p_gt    = c_gt;
      assign p_unord = c_unord;
      assign p_mode  = mode;
   end else begin : g_two
      logic       s1_valid_q, s1_valid_d;
      logic [3:0] s1_flags_q, s1_flags_d;
      logic [2:0] s1_mode_q, s1_mode_d;

      always_comb begin
         s1_valid_d = s1_valid_q;
         s1_flags_d = s1_flags_q;
         s1_mode_d  = s1_mode_q;
         if (en) begin
            s1_valid_d = in_valid;
            s1_flags_d = {c_unord, c_lt, c_eq, c_gt};
            s1_mode_d  = mode;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_valid_q <= 1'b0;
            s1_flags_q <= '0;
            s1_mode_q  <= '0;
         end else begin
            s1_valid_q <= s1_valid_d;
            s1_flags_q <= s1_flags_d;
            s1_mode_q  <= s1_mode_d;
         end
      end

      assign p_valid = s1_valid_q;
      assign {p_unord, p_lt, p_eq, p_gt} = s1_flags_q;
      assign p_mode  = s1_mode_q;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      unord_d     = unord_q;
      lt_d        = lt_q;
      eq_d        = eq_q;
      gt_d        = gt_q;
      if (en) begin
         out_valid_d = p_valid;
         result_d    = decode_mode(p_mode, p_lt, p_eq, p_gt);
         unord_d     = p_unord;
         lt_d        = p_lt;
         eq_d        = p_eq;
         gt_d        = p_gt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= 1'b0;
         unord_q     <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         unord_q     <= unord_d;
         lt_q        <= lt_d;
         eq_q        <= eq_d;
         gt_q        <= gt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign unordered = unord_q;
   assign lt        = lt_q;
   assign eq        = eq_q;
   assign gt        = gt_q;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: directed test-plan vectors, a randomized
// stream against a signed-rank reference model, stall and mid-stream reset scenarios.
module tb_fp_compare_pipe;

   localparam int unsigned WE     = 11;
   localparam int unsigned WF     = 20;
   localparam int unsigned STAGES = 2;
   localparam int unsigned W      = WE + WF + 3;
   localparam int          LAT    = STAGES;

   localparam logic [W-1:0] P_ONE  = 34'h13FF00000;
   localparam logic [W-1:0] P_TWO  = 34'h140000000;
   localparam logic [W-1:0] P_ZERO = 34'h000000000;
   localparam logic [W-1:0] N_ZERO = 34'h080000000;
   localparam logic [W-1:0] Q_NAN  = 34'h300000000;
   localparam logic [W-1:0] N_INF  = 34'h280000000;
   localparam logic [W-1:0] N_TWO  = 34'h1C0000000;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [2:0]   mode;
   logic         out_valid;
   logic         out_ready;
   logic         result;
   logic         unordered;
   logic         lt;
   logic         eq;
   logic         gt;

   int checks = 0;
   int errors = 0;
   logic [4:0] sb[$];

   always #5 clk = ~clk;

   fp_compare_pipe #(
      .WE    (WE),
      .WF    (WF),
      .STAGES(STAGES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .mode     (mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .unordered(unordered),
      .lt       (lt),
      .eq       (eq),
      .gt       (gt)
   );

   // Maps an ordered operand onto a signed integer line: -mag .. +mag, both zeros at 0.
   function automatic longint rank(input logic [W-1:0] op);
      logic [1:0] exn;
      longint     mag;
      exn = op[W-1 -: 2];
      case (exn)
         2'b01:   mag = (longint'(1) << (WE + WF)) + longint'(op[WE+WF-1:0]);
         2'b10:   mag = longint'(2) << (WE + WF);
         default: mag = 0;
      endcase
      return op[W-3] ? -mag : mag;
   endfunction

   // Returns {result, unordered, lt, eq, gt}.
   function automatic logic [4:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] m);
      longint ra, rb;
      logic   r;
      if (a[W-1 -: 2] == 2'b11 || b[W-1 -: 2] == 2'b11) return {(m == 3'd3), 4'b1000};
      ra = rank(a);
      rb = rank(b);
      case (m)
         3'd0:    r = ra < rb;
         3'd1:    r = ra <= rb;
         3'd2:    r = ra == rb;
         3'd3:    r = ra != rb;
         3'd4:    r = ra >= rb;
         3'd5:    r = ra > rb;
         default: r = 1'b0;
      endcase
      return {r, 1'b0, ra < rb, ra == rb, ra > rb};
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] op;
      op[W-1 -: 2]     = 2'($urandom_range(0, 3));
      op[W-3]          = 1'($urandom_range(0, 1));
      op[WE+WF-1:WF]   = WE'(11'h3FE + 11'($urandom_range(0, 2)));
      op[WF-1:0]       = WF'($urandom_range(0, 2));
      return op;
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; mode = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, result, unordered, lt, eq, gt} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 000000",
                  {out_valid, result, unordered, lt, eq, gt});
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [W-1:0] da[10];
      logic [W-1:0] db[10];
      logic [2:0]   dm[10];
      logic         dr[10];
      logic [4:0]   e;
      int           cyc;
      da[0] = P_ONE;  db[0] = P_TWO;  dm[0] = 3'd1; dr[0] = 1'b1;
      da[1] = P_ZERO; db[1] = N_ZERO; dm[1] = 3'd2; dr[1] = 1'b1;
      da[2] = P_ZERO; db[2] = N_ZERO; dm[2] = 3'd0; dr[2] = 1'b0;
      da[3] = Q_NAN;  db[3] = P_ONE;  dm[3] = 3'd3; dr[3] = 1'b1;
      da[4] = Q_NAN;  db[4] = P_ONE;  dm[4] = 3'd1; dr[4] = 1'b0;
      da[5] = Q_NAN;  db[5] = P_ONE;  dm[5] = 3'd4; dr[5] = 1'b0;
      da[6] = N_INF;  db[6] = N_TWO;  dm[6] = 3'd0; dr[6] = 1'b1;
      da[7] = N_TWO;  db[7] = N_INF;  dm[7] = 3'd5; dr[7] = 1'b1;
      da[8] = P_ONE;  db[8] = P_ONE;  dm[8] = 3'd6; dr[8] = 1'b0;
      da[9] = N_TWO;  db[9] = P_ZERO; dm[9] = 3'd4; dr[9] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = da[i]; in_b = db[i]; mode = dm[i]; out_ready = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0; in_a = rand_op(); in_b = rand_op(); mode = 3'($urandom_range(0, 7));
         cyc = 1;
         while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         e = ref_cmp(da[i], db[i], dm[i]);
         checks++;
         if (cyc !== LAT) begin
            errors++;
            $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, LAT);
         end
         checks++;
         if (result !== dr[i]) begin
            errors++;
            $display("FAIL dir%0d_result: got %b want %b", i, result, dr[i]);
         end
         checks++;
         if ({unordered, lt, eq, gt} !== e[3:0]) begin
            errors++;
            $display("FAIL dir%0d_flags: got %b want %b", i, {unordered, lt, eq, gt}, e[3:0]);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] e;
      for (int c = 0; c < 460; c++) begin
         @(negedge clk);
         if (c < 400) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         in_a = rand_op();
         in_b = ($urandom_range(0, 3) == 0) ? in_a : rand_op();
         mode = 3'($urandom_range(0, 7));
         #1;
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL rnd_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rnd_spurious: got output %b want none",
                        {result, unordered, lt, eq, gt});
            end else begin
               e = sb.pop_front();
               if ({result, unordered, lt, eq, gt} !== e) begin
                  errors++;
                  $display("FAIL rnd_result: got %b want %b", {result, unordered, lt, eq, gt}, e);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(ref_cmp(in_a, in_b, mode));
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL rnd_drain: got %0d pending want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] va[4];
      logic [W-1:0] vb[4];
      logic [2:0]   vm[4];
      logic [5:0]   snap;
      logic [4:0]   e;
      bit           have_snap = 0;
      bit           saw_stall = 0;
      int           sent = 0;
      int           recv = 0;
      for (int i = 0; i < 4; i++) begin
         va[i] = rand_op();
         vb[i] = rand_op();
         vm[i] = 3'($urandom_range(0, 5));
      end
      for (int c = 0; c < 30 && recv < 4; c++) begin
         @(negedge clk);
         in_valid  = (sent < 4);
         in_a      = (sent < 4) ? va[sent] : '0;
         in_b      = (sent < 4) ? vb[sent] : '0;
         mode      = (sent < 4) ? vm[sent] : 3'd0;
         out_ready = !(c >= 2 && c <= 4);
         #1;
         if (out_valid && !out_ready) begin
            saw_stall = 1;
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_in_ready: got %b want 0", in_ready);
            end
            if (have_snap) begin
               checks++;
               if ({out_valid, result, unordered, lt, eq, gt} !== snap) begin
                  errors++;
                  $display("FAIL b2b_frozen: got %b want %b",
                           {out_valid, result, unordered, lt, eq, gt}, snap);
               end
            end else begin
               snap      = {out_valid, result, unordered, lt, eq, gt};
               have_snap = 1;
            end
         end else begin
            have_snap = 0;
         end
         if (out_valid && out_ready) begin
            checks++;
            e = (sb.size() != 0) ? sb.pop_front() : 5'bxxxxx;
            if ({result, unordered, lt, eq, gt} !== e) begin
               errors++;
               $display("FAIL b2b_order%0d: got %b want %b", recv, {result, unordered, lt, eq, gt}, e);
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(ref_cmp(in_a, in_b, mode));
            sent++;
         end
      end
      checks++;
      if (recv != 4 || sent != 4 || !saw_stall || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: got sent=%0d recv=%0d stall=%0d want 4 4 1",
                  sent, recv, saw_stall);
         sb.delete();
      end
   endtask

   task automatic test_reset_midstream();
      int   cyc;
      logic leaked = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_a = P_ONE; in_b = P_TWO; mode = 3'd0;
      @(negedge clk);
      in_a = N_TWO; in_b = N_INF; mode = 3'd5;
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_in_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid !== 1'b0) leaked = 1'b1;
      end
      checks++;
      if (leaked !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_leak: got out_valid=1 want 0");
      end
      @(negedge clk);
      in_valid = 1'b1; in_a = P_ONE; in_b = P_TWO; mode = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== LAT || result !== 1'b1 || {unordered, lt, eq, gt} !== 4'b0100) begin
         errors++;
         $display("FAIL rstmid_next: got lat=%0d res=%b flags=%b want lat=%0d res=1 flags=0100",
                  cyc, result, {unordered, lt, eq, gt}, LAT);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
